serial_magnitude_comparator: RTL
================================

# serial_magnitude_comparator

- Multi-cycle, parametrised magnitude comparator for two WIDTH-bit operands.
- Compares DIGIT bits per clock, LSB slice first; a higher slice's decision overrides lower ones.
- Supports cascade inputs, unsigned or two's-complement mode, and valid/ready handshakes on both sides.
- Replaces the fixed 8-bit ripple of 3-bit comparator slices in the datapath with a time-multiplexed single slice. Used wherever wide compares are needed without a long combinational chain.

## Interface

Parameters:
- WIDTH, 16, operand width in bits (≥2).
- DIGIT, 3, bits compared per cycle (1..WIDTH).
- NDIG (localparam), ceil(WIDTH/DIGIT), number of compare cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept a new compare.
- p  input  WIDTH  operand A.
- q  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
- l  input  1  cascade-in "less".
- e  input  1  cascade-in "equal".
- g  input  1  cascade-in "greater".
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- lt  output  1  p < q (after cascade resolution).
- et  output  1  p == q and cascade equal.
- gt  output  1  p > q (after cascade resolution).
- busy  output  1  compare in progress (BUSY state).

## Operation

FSM states: IDLE, BUSY, DONE.

IDLE:
- in_ready=1.
- On in_valid: capture p, q and signed_mode into registers.
- Initialise the running result from the cascade inputs, priority l > g > e. No bit set → equal.
- Clear the digit counter and go to BUSY.

BUSY:
- On each cycle, digit k (k = 0..NDIG-1) compares bits [k·DIGIT +: DIGIT] of both operands.
- If the digits differ, the running result becomes the digit's lt/gt. If equal, the running result is held.
- After digit NDIG-1, go to DONE.

Top digit:
- Bits above WIDTH-1 are zero-padded in both operands.
- In signed_mode, bit WIDTH-1 of both operands is inverted before the compare. Padding is applied after the inversion.

DONE:
- out_valid=1, and lt/et/gt show the final result, exactly one of them high.
- Outputs are held stable until out_ready=1, then go to IDLE.

Other rules:
- in_valid is ignored outside IDLE.
- Operand and cascade inputs are sampled only at acceptance.
- Changing inputs during BUSY or DONE has no effect.

## Timing

- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, lt=et=gt=0, digit counter=0.
- Reset asserted mid-operation aborts the compare immediately, with no output produced. The first cycle after release is IDLE with in_ready=1.
- Accept handshake: in_valid&&in_ready at cycle 0.
- busy=1 during cycles 1..NDIG. Digit k is resolved at the edge ending cycle k+1.
- out_valid rises in cycle NDIG+1 (latency NDIG+1 from acceptance).
- If out_ready=1 in that cycle, state is IDLE at NDIG+2. The next accept is possible in that cycle.
- Maximum throughput: one result per NDIG+2 cycles.
- in_ready and out_valid are decoded directly from registered state. There is no combinational path from in_valid or out_ready to either.

## Structure

Shared package (cmp_pkg):
- State enum {IDLE, BUSY, DONE}.
- 3-bit one-hot result encoding (LT=3'b100, EQ=3'b010, GT=3'b001) and the cascade-priority resolve function.

One sub-module, comparator_digit:
- Parametrised DIGIT-bit combinational compare producing lt/eq/gt.
- Instantiated once and driven by the digit-select mux.

Top level:
- Holds the FSM, the counter ($clog2(NDIG) bits, minimum 1), the operand registers and the running-result register.

## Test plan

All scenarios use WIDTH=16 and DIGIT=3 (NDIG=6) unless stated otherwise.

1. **Equal operands:** p=q=0x1234, e=1, unsigned → et=1, out_valid rises exactly 7 cycles after the accept; busy high for 6 cycles.
2. **Signed vs unsigned:** p=0x8000, q=0x7FFF. Unsigned → gt=1; signed_mode=1 → lt=1. Repeat with WIDTH=8, DIGIT=3 (padded top digit), p=0x80, q=0x7F → same two results.
3. **Cascade:** p=q=0x00FF with l=1 → lt=1. Then p=0x0001, q=0x0002 with g=1 → lt=1 (operands override cascade). Then l=g=1, operands equal → lt=1 (priority).
4. **Backpressure:** out_ready held 0 for 5 cycles after out_valid → lt/et/gt and out_valid stable, in_ready=0. An in_valid pulse with new operands is ignored; the result is accepted on the first out_ready=1.
5. **Reset mid-operation:** rst_n asserted in BUSY digit 3 → outputs immediately at reset values. After release: in_ready=1, and a new compare p=5, q=9 gives lt=1 with normal latency.
6. **Back-to-back:** in_valid=out_ready=1 continuously with random operands → a result every 8 cycles, each matching a reference model, with no lost or duplicated results.

Source files
------------

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, one-hot
// result encoding and cascade-input resolution.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] RES_LT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

    // Cascade priority is l > g > e; with no flag set the chain reads as equal.
    function automatic logic [2:0] resolve_cascade(input logic l_i, input logic e_i, input logic g_i);
        logic [2:0] res;
        if (l_i)      res = RES_LT;
        else if (g_i) res = RES_GT;
        else if (e_i) res = RES_EQ;
        else          res = RES_EQ;
        return res;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_digit.sv
// Combinational DIGIT-bit unsigned compare; one instance is time-shared
// across all digits of the operands.
module comparator_digit #(
    parameter int DIGIT = 3
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    assign lt_o = (a_i <  b_i);
    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands DIGIT bits per clock,
// LSB digit first, so a more significant differing digit has the last word.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic             signed_mode,
    input  logic             l,
    input  logic             e,
    input  logic             g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             et,
    output logic             gt,
    output logic             busy
);

    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int PW   = NDIG * DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    state_e           state_q;
    logic [WIDTH-1:0] p_q, q_q;
    logic             mode_q;
    logic [2:0]       res_q, res_d;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] p_eff, q_eff;
    logic [PW-1:0]    p_pad, q_pad;
    logic [DIGIT-1:0] dig_p, dig_q;
    logic             d_lt, d_eq, d_gt;

    // Flipping the sign bit maps two's-complement order onto unsigned order;
    // zero padding of the top digit is applied afterwards.
    always_comb begin
        p_eff = p_q;
        q_eff = q_q;
        p_eff[WIDTH-1] = p_q[WIDTH-1] ^ mode_q;
        q_eff[WIDTH-1] = q_q[WIDTH-1] ^ mode_q;
    end

    assign p_pad = PW'(p_eff);
    assign q_pad = PW'(q_eff);

    always_comb begin
        dig_p = '0;
        dig_q = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (cnt_q == CW'(k)) begin
                dig_p = p_pad[k*DIGIT +: DIGIT];
                dig_q = q_pad[k*DIGIT +: DIGIT];
            end
        end
    end

    comparator_digit #(.DIGIT(DIGIT)) u_digit (
        .a_i  (dig_p),
        .b_i  (dig_q),
        .lt_o (d_lt),
        .eq_o (d_eq),
        .gt_o (d_gt)
    );

    assign res_d = d_eq ? res_q : {d_lt, 1'b0, d_gt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            mode_q  <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        p_q     <= p;
                        q_q     <= q;
                        mode_q  <= signed_mode;
                        res_q   <= resolve_cascade(l, e, g);
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    res_q <= res_d;
                    if (cnt_q == LAST_DIG) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q == BUSY);
    assign out_valid    = (state_q == DONE);
    assign {lt, et, gt} = (state_q == DONE) ? res_q : 3'b000;

endmodule
